regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, entries per source FIFO (power of two, >=2) SHALL be supported.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU writeback request valid.
REQ-005 alu_ready  output  1  ALU FIFO can accept.
REQ-006 alu_rd  input  4  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 mem_valid, mem_ready, mem_rd, mem_data  in/out/in/in  1/1/4/32  load writeback channel, same semantics as ALU channel.
REQ-009 flush  input  1  discard all pending writes.
REQ-010 we3, wa3, wd3  output  1/4/32  register file write port.
REQ-011 pc_we, pc_wd  output  1/32  R15 (PC) write, never routed to the register file.
REQ-012 qa1, qa2  input  4  scoreboard query addresses.
REQ-013 busy1, busy2  output  1  pending write exists for qa1/qa2.

Function
REQ-014 Each source SHALL own a DEPTH-entry FIFO of {rd, data}; transfer occurs when valid && ready.
REQ-015 x_ready SHALL equal !full of that FIFO, from registered count only; no enqueue when full, even if popping the same cycle.
REQ-016 At most one FIFO head SHALL be granted per cycle; the grant pops that head at the cycle-ending edge.
REQ-017 Grant rule: one FIFO non-empty -> grant it, pref unchanged; both non-empty with equal head rd -> grant mem, pref := ALU; both non-empty with different rd -> grant source indicated by pref, then pref toggles.
REQ-018 Granted head with rd != 15 SHALL drive we3=1, wa3=rd, wd3=data combinationally in the grant cycle; pc_we=0.
REQ-019 Granted head with rd == 15 SHALL drive pc_we=1, pc_wd=data; we3=0.
REQ-020 With no grant, we3=0, pc_we=0; wa3, wd3, pc_wd SHALL be 0.
REQ-021 Latency: request accepted in cycle N into empty FIFO, with no competing head, SHALL be written during cycle N+1.
REQ-022 Entries from one source SHALL retire in acceptance order.
REQ-023 busyK SHALL be 1 iff any valid entry in either FIFO has rd == qaK, including the head granted this cycle; query of 15 SHALL follow the same rule.
REQ-024 flush SHALL empty both FIFOs at the cycle-ending edge, suppress we3/pc_we in that cycle, drop any same-cycle enqueue, and leave pref unchanged.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; simultaneous enqueue and pop on a non-full FIFO SHALL keep count unchanged.

Reset
REQ-026 While reset is high: both FIFOs empty, pref := ALU, we3=0, pc_we=0, busy1=busy2=0, alu_ready=mem_ready=0 in the reset cycle, 1 in the first cycle after reset deasserts.
REQ-027 reset SHALL override flush and all requests; entries presented during reset SHALL be discarded.

Verification
REQ-028 ALU accepts rd=3, data=0x11 in cycle 1 -> cycle 2: we3=1, wa3=3, wd3=0x11; cycle 3: we3=0.
REQ-029 Both FIFOs hold heads rd=1 (ALU) and rd=2 (mem) after reset -> grants ALU, mem, ALU-next, in alternating order.
REQ-030 ALU head rd=5/0xAA, mem head rd=5/0xBB -> mem written first (0xBB), then ALU (0xAA); final R5=0xAA.
REQ-031 mem rd=15, data=0x100 -> pc_we=1, pc_wd=0x100, we3=0.
REQ-032 Fill ALU FIFO to DEPTH while mem stream wins grants -> alu_ready=0; no entry lost; busy1 with qa1=rd holds until that entry retires.
REQ-033 flush with 2 pending entries plus a new valid -> next cycle FIFOs empty, no write issued, busy=0; reset mid-stream -> same result.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two DEPTH-entry FIFOs (ALU, load) compete for one register-file
// write port; R15 writes are diverted to the PC port. Also answers pending-write queries.
module regfile_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        flush,
   output logic        we3,
   output logic [3:0]  wa3,
   output logic [31:0] wd3,
   output logic        pc_we,
   output logic [31:0] pc_wd,
   input  logic [3:0]  qa1,
   input  logic [3:0]  qa2,
   output logic        busy1,
   output logic        busy2
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [0:0] PREF_ALU = 1'b0;
   localparam logic [3:0] PC_REG = 4'd15;

   // Index 0 is the ALU source, index 1 the load source.
   logic [3:0]       rd_q   [2][DEPTH];
   logic [3:0]       rd_d   [2][DEPTH];
   logic [31:0]      data_q [2][DEPTH];
   logic [31:0]      data_d [2][DEPTH];
   logic [DEPTH-1:0] vld_q  [2];
   logic [DEPTH-1:0] vld_d  [2];
   logic [PW-1:0]    wp_q   [2];
   logic [PW-1:0]    wp_d   [2];
   logic [PW-1:0]    rp_q   [2];
   logic [PW-1:0]    rp_d   [2];
   logic [CW-1:0]    cnt_q  [2];
   logic [CW-1:0]    cnt_d  [2];
   logic [0:0]       pref_q;
   logic [0:0]       pref_d;

   logic [1:0]  in_vld;
   logic [3:0]  in_rd   [2];
   logic [31:0] in_data [2];
   logic [1:0]  full;
   logic [1:0]  nempty;
   logic [1:0]  push;
   logic [1:0]  pop;
   logic [3:0]  head_rd   [2];
   logic [31:0] head_data [2];
   logic        grant_any;
   logic [0:0]  grant_src;

   always_comb begin
      in_vld     = {mem_valid, alu_valid};
      in_rd[0]   = alu_rd;
      in_rd[1]   = mem_rd;
      in_data[0] = alu_data;
      in_data[1] = mem_data;
      for (int s = 0; s < 2; s++) begin
         full[s]      = (cnt_q[s] == FULL_CNT);
         nempty[s]    = (cnt_q[s] != '0);
         head_rd[s]   = rd_q[s][rp_q[s]];
         head_data[s] = data_q[s][rp_q[s]];
         // Flush and reset both drop any same-cycle enqueue.
         push[s]      = in_vld[s] && !full[s] && !reset && !flush;
      end
   end

   // Ready depends only on the registered count, so a full FIFO refuses even while popping.
   assign alu_ready = !full[0] && !reset;
   assign mem_ready = !full[1] && !reset;

   always_comb begin
      grant_any = 1'b0;
      grant_src = 1'b0;
      pref_d    = pref_q;
      if (!reset && !flush) begin
         if (nempty[0] && nempty[1]) begin
            grant_any = 1'b1;
            // Same destination: the load retires first so the ALU result lands last.
            if (head_rd[0] == head_rd[1]) begin
               grant_src = 1'b1;
               pref_d    = PREF_ALU;
            end else begin
               grant_src = pref_q;
               pref_d    = ~pref_q;
            end
         end else if (nempty[0]) begin
            grant_any = 1'b1;
            grant_src = 1'b0;
         end else if (nempty[1]) begin
            grant_any = 1'b1;
            grant_src = 1'b1;
         end
      end
      pop = grant_any ? (2'b01 << grant_src) : 2'b00;
   end

   always_comb begin
      we3   = 1'b0;
      wa3   = '0;
      wd3   = '0;
      pc_we = 1'b0;
      pc_wd = '0;
      if (grant_any) begin
         if (head_rd[grant_src] == PC_REG) begin
            pc_we = 1'b1;
            pc_wd = head_data[grant_src];
         end else begin
            we3 = 1'b1;
            wa3 = head_rd[grant_src];
            wd3 = head_data[grant_src];
         end
      end
   end

   always_comb begin
      rd_d   = rd_q;
      data_d = data_q;
      vld_d  = vld_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      for (int s = 0; s < 2; s++) begin
         if (flush) begin
            vld_d[s] = '0;
            wp_d[s]  = '0;
            rp_d[s]  = '0;
            cnt_d[s] = '0;
         end else begin
            if (pop[s]) begin
               vld_d[s][rp_q[s]] = 1'b0;
               rp_d[s]           = rp_q[s] + 1'b1;
            end
            if (push[s]) begin
               vld_d[s][wp_q[s]]  = 1'b1;
               rd_d[s][wp_q[s]]   = in_rd[s];
               data_d[s][wp_q[s]] = in_data[s];
               wp_d[s]            = wp_q[s] + 1'b1;
            end
            cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
         end
      end
   end

   // Scoreboard: any live entry, including the head being written now.
   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[s][i] && (rd_q[s][i] == qa1)) busy1 = 1'b1;
            if (vld_q[s][i] && (rd_q[s][i] == qa2)) busy2 = 1'b1;
         end
      end
      if (reset) begin
         busy1 = 1'b0;
         busy2 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            vld_q[s] <= '0;
            wp_q[s]  <= '0;
            rp_q[s]  <= '0;
            cnt_q[s] <= '0;
         end
         pref_q <= PREF_ALU;
      end else begin
         vld_q  <= vld_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         pref_q <= pref_d;
      end
   end

   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2): one table row per clock cycle,
// plus a streaming sequence that exercises pointer wrap.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid, flush;
   logic        alu_ready, mem_ready;
   logic [3:0]  alu_rd, mem_rd, qa1, qa2, wa3;
   logic [31:0] alu_data, mem_data, wd3, pc_wd;
   logic        we3, pc_we, busy1, busy2;

   int n_chk = 0;
   int n_fail = 0;

   regfile_wb_arbiter #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .flush(flush),
      .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
      .qa1(qa1), .qa2(qa2), .busy1(busy1), .busy2(busy2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        av;
      logic [3:0]  ard;
      logic [31:0] ad;
      logic        mv;
      logic [3:0]  mrd;
      logic [31:0] md;
      logic        fl;
      logic [3:0]  q1, q2;
      logic        ar, mr, we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        pwe;
      logic [31:0] pwd;
      logic        b1, b2;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(input logic rst,
                              input logic av, input logic [3:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                              input logic fl, input logic [3:0] q1, input logic [3:0] q2,
                              input logic ar, input logic mr,
                              input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic pwe, input logic [31:0] pwd,
                              input logic b1, input logic b2);
      vec_t r;
      r.rst = rst; r.av = av; r.ard = ard; r.ad = ad;
      r.mv = mv; r.mrd = mrd; r.md = md; r.fl = fl; r.q1 = q1; r.q2 = q2;
      r.ar = ar; r.mr = mr; r.we = we; r.wa = wa; r.wd = wd;
      r.pwe = pwe; r.pwd = pwd; r.b1 = b1; r.b2 = b2;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @step %0d: got 0x%0h, want 0x%0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; alu_valid = 0; mem_valid = 0; flush = 0;
      alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; qa1 = 0; qa2 = 0;

      // rst | alu v,rd,data | mem v,rd,data | flush | qa1,qa2 || ar,mr | we,wa,wd | pwe,pwd | b1,b2
      vt.push_back(v(1, 1,3,'h55,   1,4,'h66,    0, 3,4,   0,0, 0,0,0,       0,0,      0,0));
      // single ALU write, one-cycle latency
      vt.push_back(v(0, 1,3,'h11,   0,0,0,       0, 3,4,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 3,4,   1,1, 1,3,'h11,    0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 3,4,   1,1, 0,0,0,       0,0,      0,0));
      // same rd in both heads: load first, then ALU
      vt.push_back(v(0, 1,5,'hAA,   1,5,'hBB,    0, 5,0,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 5,0,   1,1, 1,5,'hBB,    0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 5,0,   1,1, 1,5,'hAA,    0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 5,0,   1,1, 0,0,0,       0,0,      0,0));
      // different rds: round robin starting with ALU
      vt.push_back(v(0, 1,1,'hA1,   1,2,'hB2,    0, 6,7,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 1,6,'hA6,   1,7,'hB7,    0, 6,7,   1,1, 1,1,'hA1,    0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 6,7,   1,0, 1,2,'hB2,    0,0,      1,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 6,7,   1,1, 1,6,'hA6,    0,0,      1,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 6,7,   1,1, 1,7,'hB7,    0,0,      0,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 6,7,   1,1, 0,0,0,       0,0,      0,0));
      // R15 goes to the PC port only
      vt.push_back(v(0, 0,0,0,      1,15,'h100,  0, 15,0,  1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 15,0,  1,1, 0,0,0,       1,'h100,  1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 15,0,  1,1, 0,0,0,       0,0,      0,0));
      // ALU FIFO fills while loads keep winning; blocked entry 11 must not sneak in
      vt.push_back(v(0, 1,9,'h90,   1,9,'hC0,    0, 9,10,  1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 1,10,'h9A,  1,9,'hC1,    0, 9,10,  1,1, 1,9,'hC0,    0,0,      1,0));
      vt.push_back(v(0, 1,11,'hBB,  1,9,'hC2,    0, 9,10,  0,1, 1,9,'hC1,    0,0,      1,1));
      vt.push_back(v(0, 1,11,'hBB,  0,0,0,       0, 9,10,  0,1, 1,9,'hC2,    0,0,      1,1));
      vt.push_back(v(0, 1,11,'hBB,  0,0,0,       0, 9,10,  0,1, 1,9,'h90,    0,0,      1,1));
      vt.push_back(v(0, 1,11,'hBB,  0,0,0,       0, 9,10,  1,1, 1,10,'h9A,   0,0,      0,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 11,10, 1,1, 1,11,'hBB,   0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 11,10, 1,1, 0,0,0,       0,0,      0,0));
      // flush with pending entries and new requests; pref survives the flush
      vt.push_back(v(0, 1,1,'h01,   1,2,'h02,    0, 3,2,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 1,3,'h03,   0,0,0,       0, 3,2,   1,1, 1,1,'h01,    0,0,      0,1));
      vt.push_back(v(0, 1,4,'h04,   1,6,'h06,    1, 3,2,   1,1, 0,0,0,       0,0,      1,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 4,6,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 1,1,'h11,   1,2,'h22,    0, 1,2,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 1,2,   1,1, 1,2,'h22,    0,0,      1,1));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 1,2,   1,1, 1,1,'h11,    0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 1,2,   1,1, 0,0,0,       0,0,      0,0));
      // reset mid-stream discards everything, then normal operation resumes
      vt.push_back(v(0, 1,7,'h77,   1,8,'h88,    0, 7,8,   1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(1, 1,12,'hCC,  1,13,'hDD,   1, 7,8,   0,0, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 7,12,  1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 1,3,'h33,   0,0,0,       0, 3,13,  1,1, 0,0,0,       0,0,      0,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 3,13,  1,1, 1,3,'h33,    0,0,      1,0));
      vt.push_back(v(0, 0,0,0,      0,0,0,       0, 3,13,  1,1, 0,0,0,       0,0,      0,0));

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         reset = vt[i].rst;
         alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
         mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
         flush = vt[i].fl; qa1 = vt[i].q1; qa2 = vt[i].q2;
         #1;
         chk("alu_ready", i, alu_ready, vt[i].ar);
         chk("mem_ready", i, mem_ready, vt[i].mr);
         chk("we3",       i, we3,       vt[i].we);
         chk("wa3",       i, wa3,       vt[i].wa);
         chk("wd3",       i, wd3,       vt[i].wd);
         chk("pc_we",     i, pc_we,     vt[i].pwe);
         chk("pc_wd",     i, pc_wd,     vt[i].pwd);
         chk("busy1",     i, busy1,     vt[i].b1);
         chk("busy2",     i, busy2,     vt[i].b2);
      end

      // Back-to-back ALU stream: push and pop each cycle, pointers wrap, order kept.
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         reset = 0; flush = 0; mem_valid = 0; qa1 = 0; qa2 = 0;
         alu_valid = (k < 6);
         alu_rd    = 4'(k + 1);
         alu_data  = 32'h200 + 32'(k);
         #1;
         chk("stream_ready", 100 + k, alu_ready, 1'b1);
         chk("stream_we3",   100 + k, we3, (k != 0));
         if (k != 0) begin
            chk("stream_wa3", 100 + k, wa3, 4'(k));
            chk("stream_wd3", 100 + k, wd3, 32'h200 + 32'(k - 1));
         end
      end
      @(negedge clk);
      alu_valid = 0;
      #1;
      chk("stream_idle_we3", 107, we3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
